// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit
//
// Hardware operand stack (LIFO) for the multi-cycle stack CPU. The controller
// drives push/pop/tos strobes directly; the popped or top-of-stack word comes
// back in a registered d_out one cycle later, flagged by a one-cycle d_valid.
//
// Optional feature macro: STACK_ERR_TRAP_EN
//   defined   : overflow/underflow events set sticky ovf_err/unf_err flags.
//   undefined : ovf_err/unf_err are tied to 0, no flag registers exist.
//
// Ports:
//   clk      in   rising-edge system clock
//   rst      in   asynchronous, active-low reset
//   push     in   write d_in as the new top-of-stack
//   pop      in   remove top-of-stack and copy it to d_out
//   tos      in   copy top-of-stack to d_out without removing it
//   d_in     in   [WIDTH-1:0] word to push
//   d_out    out  [WIDTH-1:0] registered read result
//   d_valid  out  pulse: d_out was updated by the previous edge
//   count    out  [CW-1:0] number of entries, 0..DEPTH
//   empty    out  count == 0
//   full     out  count == DEPTH
//   ovf_err  out  sticky overflow flag
//   unf_err  out  sticky underflow flag
//
// Command semantics: push/pop/tos are single-cycle strobes sampled on every
// rising edge. There is no ready/back-pressure; every command is either
// carried out at that edge or fails without changing any state. d_valid is a
// one-cycle response pulse for a successful pop, tos or push+pop swap.
// ---------------------------------------------------------------------------
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_nxt;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    sp_idx;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic             rd_en;

    assign count = sp;
    assign empty = (sp == '0);
    assign full  = (sp == FULL_CNT);

    // top_idx is only used when the stack is non-empty and sp_idx only when
    // it is not full, so the truncations below never select a bad entry.
    assign top_idx = AW'(sp - CW'(1));
    assign sp_idx  = AW'(sp);

    // Command decode. push and pop together form a swap; tos only counts
    // when neither push nor pop is asserted.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = top_idx;
        rd_en     = 1'b0;
        sp_nxt    = sp;
        if (push && pop) begin
            if (!empty) begin
                // Swap: read the old top and overwrite it in the same edge.
                mem_we    = 1'b1;
                mem_waddr = top_idx;
                rd_en     = 1'b1;
            end else begin
                // Nothing to pop: degrade to a plain push (cannot be full).
                mem_we    = 1'b1;
                mem_waddr = sp_idx;
                sp_nxt    = sp + CW'(1);
            end
        end else if (push) begin
            if (!full) begin
                mem_we    = 1'b1;
                mem_waddr = sp_idx;
                sp_nxt    = sp + CW'(1);
            end
        end else if (pop) begin
            if (!empty) begin
                rd_en  = 1'b1;
                sp_nxt = sp - CW'(1);
            end
        end else if (tos) begin
            rd_en = !empty;
        end
    end

    // Storage array is intentionally not reset; entries are only read after
    // being written because sp guards every access.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp      <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
        end else begin
            sp      <= sp_nxt;
            d_valid <= rd_en;
            if (rd_en) begin
                d_out <= mem[top_idx];
            end
        end
    end

`ifdef STACK_ERR_TRAP_EN
    logic ovf_ev;
    logic unf_ev;

    // Overflow: a lone push into a full stack (a swap never overflows).
    // Underflow: pop (alone or as swap) or a lone tos on an empty stack.
    assign ovf_ev = push && !pop && full;
    assign unf_ev = empty && (pop || (tos && !push));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (ovf_ev) ovf_err <= 1'b1;
            if (unf_ev) unf_err <= 1'b1;
        end
    end
`else
    assign ovf_err = 1'b0;
    assign unf_err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit
//
// Self-checking bench for stack_unit with DEPTH=4, WIDTH=8. A behavioural
// reference keeps the stack contents in a queue (exp_q, top at the back) and
// the expected d_out/d_valid/flag values; every cycle all DUT outputs are
// compared against it. Directed scenarios are followed by random commands.
// ---------------------------------------------------------------------------
module tb_stack_unit;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

`ifdef STACK_ERR_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          tos = 1'b0;
    logic [W-1:0]  d_in = '0;
    logic [W-1:0]  d_out;
    logic          d_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf_err;
    logic          unf_err;

    always #5 clk = ~clk;

    stack_unit #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .tos     (tos),
        .d_in    (d_in),
        .d_out   (d_out),
        .d_valid (d_valid),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_dout;
    logic         m_valid;
    logic         m_ovf;
    logic         m_unf;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Stack rules applied to the queue for one clock edge.
    task automatic model_step(input logic p, input logic po, input logic t, input logic [W-1:0] d);
        m_valid = 1'b0;
        if (p && po) begin
            if (exp_q.size() > 0) begin
                m_dout = exp_q[exp_q.size()-1];
                exp_q[exp_q.size()-1] = d;
                m_valid = 1'b1;
            end else begin
                exp_q.push_back(d);
                m_unf = 1'b1;
            end
        end else if (p) begin
            if (exp_q.size() < D) exp_q.push_back(d);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (exp_q.size() > 0) begin
                m_dout  = exp_q.pop_back();
                m_valid = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end else if (t) begin
            if (exp_q.size() > 0) begin
                m_dout  = exp_q[exp_q.size()-1];
                m_valid = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end
    endtask

    task automatic check_state(input string ctx);
        chk({ctx, ".count"},   32'(count),   32'(exp_q.size()));
        chk({ctx, ".empty"},   32'(empty),   32'(exp_q.size() == 0));
        chk({ctx, ".full"},    32'(full),    32'(exp_q.size() == D));
        chk({ctx, ".d_valid"}, 32'(d_valid), 32'(m_valid));
        chk({ctx, ".d_out"},   32'(d_out),   32'(m_dout));
        chk({ctx, ".ovf_err"}, 32'(ovf_err), 32'(TRAP & m_ovf));
        chk({ctx, ".unf_err"}, 32'(unf_err), 32'(TRAP & m_unf));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at posedge+1 (or later) and are consumed at the next edge;
    // outputs are sampled 1 ns after that edge.
    task automatic do_cmd(input string ctx, input logic p, input logic po, input logic t,
                          input logic [W-1:0] d);
        push = p;
        pop  = po;
        tos  = t;
        d_in = d;
        @(posedge clk);
        #1;
        model_step(p, po, t, d);
        check_state(ctx);
    endtask

    // Asynchronous reset asserted between edges and checked before any edge.
    task automatic apply_reset(input string ctx);
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_state(ctx);
        #2;
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        #3;
        rst = 1'b1;

        // LIFO order with back-to-back pops.
        do_cmd("p11", 1, 0, 0, 8'h11);
        do_cmd("p22", 1, 0, 0, 8'h22);
        do_cmd("p33", 1, 0, 0, 8'h33);
        do_cmd("pop1", 0, 1, 0, 8'h00);
        chk("pop1_lit", 32'(d_out), 32'h33);
        do_cmd("pop2", 0, 1, 0, 8'h00);
        chk("pop2_lit", 32'(d_out), 32'h22);
        do_cmd("pop3", 0, 1, 0, 8'h00);
        chk("pop3_lit", 32'(d_out), 32'h11);
        chk("pop3_empty", 32'(empty), 32'h1);
        do_cmd("idle1", 0, 0, 0, 8'h00);
        chk("hold_dout", 32'(d_out), 32'h11);

        // Fill, then overflow.
        apply_reset("rst_a");
        for (int i = 0; i < 4; i++) do_cmd("fill", 1, 0, 0, 8'hA0 + W'(i));
        do_cmd("ovf_push", 1, 0, 0, 8'hFF);
        chk("ovf_count", 32'(count), 32'd4);
        do_cmd("ovf_idle", 0, 0, 0, 8'h00);
        do_cmd("ovf_pop", 0, 1, 0, 8'h00);
        chk("ovf_pop_lit", 32'(d_out), 32'hA3);

        // Underflow from reset.
        apply_reset("rst_b");
        do_cmd("unf_pop", 0, 1, 0, 8'h00);
        do_cmd("unf_tos", 0, 0, 1, 8'h00);
        chk("unf_dout_lit", 32'(d_out), 32'h00);

        // tos and swap.
        apply_reset("rst_c");
        do_cmd("p05", 1, 0, 0, 8'h05);
        do_cmd("tos1", 0, 0, 1, 8'h00);
        do_cmd("tos2", 0, 0, 1, 8'h00);
        chk("tos2_lit", 32'(d_out), 32'h05);
        do_cmd("swap09", 1, 1, 0, 8'h09);
        chk("swap09_lit", 32'(d_out), 32'h05);
        do_cmd("pop09", 0, 1, 0, 8'h00);
        chk("pop09_lit", 32'(d_out), 32'h09);
        do_cmd("swap_empty", 1, 1, 1, 8'h6C);
        do_cmd("tos_push_ign", 1, 0, 1, 8'h6D);

        // Swap on a full stack.
        apply_reset("rst_d");
        for (int i = 0; i < 4; i++) do_cmd("fill2", 1, 0, 0, 8'hB0 + W'(i));
        do_cmd("swap_full", 1, 1, 0, 8'h7E);
        chk("swap_full_lit", 32'(d_out), 32'hB3);
        do_cmd("pop7e", 0, 1, 0, 8'h00);
        chk("pop7e_lit", 32'(d_out), 32'h7E);

        // Reset mid-sequence.
        do_cmd("p44", 1, 0, 0, 8'h44);
        do_cmd("p55", 1, 0, 0, 8'h55);
        apply_reset("rst_mid");
        do_cmd("post_rst_pop", 0, 1, 0, 8'h00);

        // Random commands against the reference.
        apply_reset("rst_rand");
        for (int i = 0; i < 600; i++) begin
            logic rp;
            logic rpo;
            logic rt;
            rp  = ($urandom_range(0, 99) < 50);
            rpo = ($urandom_range(0, 99) < 40);
            rt  = ($urandom_range(0, 99) < 30);
            do_cmd("rand", rp, rpo, rt, W'($urandom_range(0, 255)));
            if ($urandom_range(0, 149) == 0) apply_reset("rand_rst");
        end

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the multi-cycle stack CPU: a LIFO of WIDTH-bit words driven directly by the controller's push, pop and tos strobes. Sits beside the datapath. It takes its push operand from the datapath's memory-read or ALU-result path and returns the popped or top-of-stack word in a registered output that the datapath's operand registers (A/B) capture one cycle later. It tracks occupancy, flags full/empty, and optionally traps overflow and underflow.

## Interface
Parameters:
- WIDTH, 8, data word width.
- DEPTH, 8, number of stack entries (≥2, power of two not required).
- CW, $clog2(DEPTH+1), width of count.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately when low.
- push  in  1  write d_in as new top-of-stack.
- pop  in  1  remove top-of-stack, copy it to d_out.
- tos  in  1  copy top-of-stack to d_out without removing it.
- d_in  in  WIDTH  word to push.
- d_out  out  WIDTH  registered read result.
- d_valid  out  1  one-cycle pulse: d_out updated by the previous edge.
- count  out  CW  current number of entries, 0..DEPTH.
- empty  out  1  count == 0 (combinational from count).
- full  out  1  count == DEPTH (combinational from count).
- ovf_err  out  1  sticky overflow flag (see Configuration).
- unf_err  out  1  sticky underflow flag (see Configuration).

## Operation
- Storage: DEPTH×WIDTH register array plus stack pointer sp (= count). The top entry is mem[sp-1]. The array is not reset; its contents are unobservable until written.
- Command decode, evaluated each rising edge:
  - push only: if !full, mem[sp]←d_in, sp←sp+1. If full, no change; overflow event.
  - pop only: if !empty, d_out←mem[sp-1], sp←sp-1, d_valid←1. If empty, no change; underflow event.
  - tos only (or tos with no push/pop): if !empty, d_out←mem[sp-1], sp unchanged, d_valid←1. If empty, underflow event.
  - push+pop (swap): if !empty, d_out←old mem[sp-1], mem[sp-1]←d_in, sp unchanged, d_valid←1. Valid even when full. If empty, behaves as push only and raises an underflow event.
  - tos asserted together with push and/or pop: tos is ignored; decode as above.
  - none asserted: hold; d_valid←0.
- Failed commands never modify mem, sp or d_out. d_valid stays 0 for a failed pop or tos.
- Arithmetic: sp is CW bits and saturates by rule (guarded by full/empty), never wraps.

## Timing
- Reset (rst low, async): sp=0, count=0, empty=1, full=0, d_out=0, d_valid=0, ovf_err=0, unf_err=0. Deassertion is sampled synchronously by downstream logic; the first command is accepted on the first rising edge with rst high.
- Read latency: 1 cycle. A pop/tos at edge N makes d_out valid after edge N, with d_valid high for the cycle N..N+1. The datapath captures at edge N+1.
- d_out holds its last value until the next successful pop/tos/swap.
- count/empty/full update at the same edge as the command.
- Back-to-back pops on consecutive cycles are supported at full rate. Push then tos on the next cycle returns the pushed word.
- Reset mid-sequence discards all entries; no partial writes are visible after reset.

## Configuration
- STACK_ERR_TRAP_EN defined: overflow events set ovf_err and underflow events set unf_err. Both flags are sticky until reset and do not block further commands.
- Not defined: ovf_err and unf_err are tied to 0 and no flag registers are synthesised. Failed commands are still silently ignored as specified.

## Test plan
- DEPTH=4, WIDTH=8. Reset, push 0x11,0x22,0x33, pop ×3 -> d_out 0x33,0x22,0x11 on successive cycles, d_valid high each cycle, count 3→0, empty=1 at end.
- Push 0xA0..0xA3 (full=1), push 0xFF -> count stays 4, later pops return 0xA3 first; with STACK_ERR_TRAP_EN ovf_err=1 and stays 1, without it ovf_err=0.
- From reset, pop, then tos -> d_out=0, d_valid=0, count=0; with macro unf_err=1.
- Push 0x05, tos, tos -> d_out=0x05 twice, count stays 1; then push+pop with d_in=0x09 -> d_out=0x05, count=1, next pop returns 0x09.
- Full stack (4 entries), push+pop with d_in=0x7E -> no ovf_err, count=4, d_out=old top, next pop returns 0x7E.
- Push 0x44, 0x55, then assert rst low mid-cycle -> count=0, d_out=0, flags 0 immediately (before next edge); a pop after release underflows.
